// File: rtl/traffic_node_if.sv
// Flit link between a traffic node and its switch port.
// The node side is the master: it drives the outgoing flit, its valid and
// its own ready; the switch side drives the return direction.
interface traffic_node_if #(
    parameter int FLIT_SIZE = 13
);
    logic [FLIT_SIZE-1:0] data_o;
    logic                 out_w;
    logic                 in_r;
    logic [FLIT_SIZE-1:0] data_i;
    logic                 in_w;
    logic                 out_r;

    modport master (
        output data_o, out_w, out_r,
        input  in_r, data_i, in_w
    );

    modport slave (
        input  data_o, out_w, out_r,
        output in_r, data_i, in_w
    );
endinterface

// File: rtl/traffic_node.sv
// Traffic generator and checker standing in for a node's IP on a switch link.
// Generates packets to a configurable destination pattern at a fixed start
// period and collects saturating receive statistics on the return path.
module traffic_node #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 4,
    parameter int ADDR         = 0,
    parameter int NODES_NUM    = 16,
    parameter int MODE         = 0,
    parameter int FIXED_DEST   = 1,
    parameter int PACK_LEN     = 4,
    parameter int PACKS_TO_GEN = 8,
    parameter int PERIOD       = 10,
    parameter int CNT_SIZE     = 16
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                en,
    traffic_node_if.master      link,
    output logic                done,
    output logic [CNT_SIZE-1:0] sent_packs,
    output logic [CNT_SIZE-1:0] recv_packs,
    output logic [CNT_SIZE-1:0] recv_flits,
    output logic [CNT_SIZE-1:0] err_cnt
);

    localparam int FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int IDX_W     = (PACK_LEN > 1) ? $clog2(PACK_LEN) : 1;
    localparam int PER_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(PACK_LEN - 1);
    localparam logic [PER_W-1:0]     PER_LOAD   = PER_W'(PERIOD - 1);
    localparam logic [ADDR_SIZE-1:0] MY_ADDR    = ADDR_SIZE'(ADDR);
    localparam logic [ADDR_SIZE-1:0] INV_ADDR   = ~MY_ADDR;
    localparam logic [CNT_SIZE:0]    PACKS_GOAL = (CNT_SIZE + 1)'(PACKS_TO_GEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    logic                   out_w_reg;
    logic [FLIT_SIZE-1:0]   data_o_reg;
    logic                   done_reg;
    logic                   out_r_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [PER_W-1:0]       per_reg;
    logic [ADDR_SIZE-1:0]   dest_reg;
    logic [15:0]            lfsr_reg;
    logic [CNT_SIZE-1:0]    sent_reg;

    logic [15:0]            lfsr_next;
    logic [ADDR_SIZE-1:0]   lfsr_mod;
    logic [ADDR_SIZE-1:0]   dest_next;
    logic                   last_pack;
    logic [2:0]             rx_hit;

    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
        return (&v) ? v : v + CNT_SIZE'(1);
    endfunction

    // Head flit carries the source address as payload, body flits their index.
    function automatic logic [FLIT_SIZE-1:0] make_flit(input logic [IDX_W-1:0] k,
                                                       input logic [ADDR_SIZE-1:0] d);
        logic [DATA_SIZE-1:0] payload;
        payload = (k == '0) ? DATA_SIZE'(ADDR) : DATA_SIZE'(k);
        return {(k == LAST_IDX), d, payload};
    endfunction

    // Fibonacci LFSR x^16+x^14+x^13+x^11, stepped once per destination latch.
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign lfsr_mod  = ADDR_SIZE'(32'(lfsr_next) % NODES_NUM);

    // Destination chosen at each packet start; random mode never targets itself.
    always_comb begin
        dest_next = '0;
        case (MODE)
            0:       dest_next = (lfsr_mod == MY_ADDR) ? ADDR_SIZE'((32'(lfsr_mod) + 1) % NODES_NUM)
                                                        : lfsr_mod;
            1:       dest_next = ADDR_SIZE'(FIXED_DEST);
            2:       dest_next = ADDR_SIZE'(32'(INV_ADDR) % NODES_NUM);
            default: dest_next = ADDR_SIZE'((ADDR + 1) % NODES_NUM);
        endcase
    end

    // The packet being finished is the last of a finite budget.
    assign last_pack = (PACKS_TO_GEN != 0) && (({1'b0, sent_reg} + (CNT_SIZE + 1)'(1)) == PACKS_GOAL);

    // Generator FSM: all link outputs are registered so they hold under backpressure.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_reg  <= IDLE;
            out_w_reg  <= 1'b0;
            data_o_reg <= '0;
            done_reg   <= 1'b0;
            out_r_reg  <= 1'b0;
            idx_reg    <= '0;
            per_reg    <= '0;
            dest_reg   <= '0;
            lfsr_reg   <= 16'(ADDR + 1);
            sent_reg   <= '0;
        end else begin
            out_r_reg <= 1'b1;
            // Start-to-start timer keeps running through stalls and the gap.
            if ((state_reg == SEND || state_reg == WAIT) && per_reg != '0) begin
                per_reg <= per_reg - PER_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_reg  <= SEND;
                        per_reg    <= PER_LOAD;
                        dest_reg   <= dest_next;
                        lfsr_reg   <= lfsr_next;
                        idx_reg    <= '0;
                        out_w_reg  <= 1'b1;
                        data_o_reg <= make_flit('0, dest_next);
                    end
                end
                SEND: begin
                    if (link.in_r) begin
                        if (idx_reg == LAST_IDX) begin
                            sent_reg <= sat_inc(sent_reg);
                            if (last_pack) begin
                                state_reg <= DONE;
                                out_w_reg <= 1'b0;
                                done_reg  <= 1'b1;
                            end else if (per_reg == '0 && en) begin
                                // Period already elapsed: next packet follows without a gap.
                                per_reg    <= PER_LOAD;
                                dest_reg   <= dest_next;
                                lfsr_reg   <= lfsr_next;
                                idx_reg    <= '0;
                                data_o_reg <= make_flit('0, dest_next);
                            end else begin
                                state_reg <= WAIT;
                                out_w_reg <= 1'b0;
                            end
                        end else begin
                            idx_reg    <= idx_reg + IDX_W'(1);
                            data_o_reg <= make_flit(idx_reg + IDX_W'(1), dest_reg);
                        end
                    end
                end
                WAIT: begin
                    if (per_reg == '0 && en) begin
                        state_reg  <= SEND;
                        per_reg    <= PER_LOAD;
                        dest_reg   <= dest_next;
                        lfsr_reg   <= lfsr_next;
                        idx_reg    <= '0;
                        out_w_reg  <= 1'b1;
                        data_o_reg <= make_flit('0, dest_next);
                    end
                end
                DONE: begin
                    out_w_reg <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Receive events: 0 = any flit, 1 = tail flit, 2 = misrouted flit.
    assign rx_hit[0] = link.in_w && out_r_reg;
    assign rx_hit[1] = rx_hit[0] && link.data_i[FLIT_SIZE-1];
    assign rx_hit[2] = rx_hit[0] && (link.data_i[FLIT_SIZE-2 -: ADDR_SIZE] != MY_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rx
            logic [CNT_SIZE-1:0] cnt_reg;
            // Saturating receive statistic for event gi.
            always_ff @(posedge clk or posedge a_rst) begin
                if (a_rst) begin
                    cnt_reg <= '0;
                end else if (rx_hit[gi]) begin
                    cnt_reg <= sat_inc(cnt_reg);
                end
            end
        end
    endgenerate

    assign link.data_o = data_o_reg;
    assign link.out_w  = out_w_reg;
    assign link.out_r  = out_r_reg;
    assign done        = done_reg;
    assign sent_packs  = sent_reg;
    assign recv_flits  = g_rx[0].cnt_reg;
    assign recv_packs  = g_rx[1].cnt_reg;
    assign err_cnt     = g_rx[2].cnt_reg;

endmodule

// File: tb/tb_traffic_node.sv
// Scoreboard bench for traffic_node: neighbour-mode generator, backpressure,
// mid-packet reset, random destinations, receive statistics and saturation.
module tb_traffic_node;

    localparam int FS = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: MODE 3, ADDR 2, 4-flit packets, budget 2 ----------------
    logic        rst_a = 1'b1, en_a = 1'b0, done_a;
    logic [15:0] sent_a, rpk_a, rfl_a, err_a;
    traffic_node_if #(.FLIT_SIZE(FS)) if_a ();
    traffic_node #(.DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(2), .NODES_NUM(16), .MODE(3),
                   .FIXED_DEST(1), .PACK_LEN(4), .PACKS_TO_GEN(2), .PERIOD(10),
                   .CNT_SIZE(16)) dut_a (
        .clk(clk), .a_rst(rst_a), .en(en_a), .link(if_a), .done(done_a),
        .sent_packs(sent_a), .recv_packs(rpk_a), .recv_flits(rfl_a), .err_cnt(err_a));

    // ---------------- DUT B: MODE 0, 5 nodes, 1-flit packets, unlimited ----------------
    logic        rst_b = 1'b1, en_b = 1'b0, done_b;
    logic [15:0] sent_b, rpk_b, rfl_b, err_b;
    traffic_node_if #(.FLIT_SIZE(FS)) if_b ();
    traffic_node #(.DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(2), .NODES_NUM(5), .MODE(0),
                   .FIXED_DEST(1), .PACK_LEN(1), .PACKS_TO_GEN(0), .PERIOD(1),
                   .CNT_SIZE(16)) dut_b (
        .clk(clk), .a_rst(rst_b), .en(en_b), .link(if_b), .done(done_b),
        .sent_packs(sent_b), .recv_packs(rpk_b), .recv_flits(rfl_b), .err_cnt(err_b));

    // ---------------- DUT C: 4-bit counters for saturation ----------------
    logic        rst_c = 1'b1, en_c = 1'b0, done_c;
    logic [3:0]  sent_c, rpk_c, rfl_c, err_c;
    traffic_node_if #(.FLIT_SIZE(FS)) if_c ();
    traffic_node #(.DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(0), .NODES_NUM(16), .MODE(0),
                   .FIXED_DEST(1), .PACK_LEN(4), .PACKS_TO_GEN(8), .PERIOD(10),
                   .CNT_SIZE(4)) dut_c (
        .clk(clk), .a_rst(rst_c), .en(en_c), .link(if_c), .done(done_c),
        .sent_packs(sent_c), .recv_packs(rpk_c), .recv_flits(rfl_c), .err_cnt(err_c));

    // ---------------- scoreboard state ----------------
    logic [FS-1:0] exp_q[$];
    int            starts[$];
    int            mon_k = 0;
    bit            head_seen = 1'b0;

    logic [3:0]    seq_q[$];
    int            b_cnt = 0;
    bit            b_phase = 1'b0;

    // Expected flit k of a DUT A packet: dest = ADDR+1 = 3, head payload = ADDR = 2.
    function automatic logic [FS-1:0] a_flit(input int k);
        logic [7:0] d;
        d = (k == 0) ? 8'd2 : 8'(k);
        return {(k == 3), 4'd3, d};
    endfunction

    task automatic push_packets(input int n);
        for (int p = 0; p < n; p++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(a_flit(k));
    endtask

    // DUT A monitor: logs packet starts and pops the scoreboard on every transfer.
    initial begin
        logic [FS-1:0] e;
        forever begin
            @(negedge clk);
            if (if_a.out_w && mon_k == 0 && !head_seen) begin
                starts.push_back(cyc);
                head_seen = 1'b1;
            end
            if (if_a.out_w && if_a.in_r) begin
                if (exp_q.size() == 0) begin
                    chk("a_unexpected_flit", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx a cyc=%0d k=%0d flit=%h", cyc, mon_k, if_a.data_o);
                    chk("a_flit", if_a.data_o, e);
                end
                mon_k = (mon_k + 1) % 4;
                if (mon_k == 0) head_seen = 1'b0;
            end
        end
    end

    // DUT B monitor: destination properties, then replay against the first run.
    initial begin
        logic [3:0] dest;
        forever begin
            @(negedge clk);
            if (if_b.out_w && if_b.in_r && b_cnt < 200) begin
                dest = if_b.data_o[11:8];
                $display("tx b run=%0d n=%0d dest=%0d", b_phase, b_cnt, dest);
                chk("b_dest_range", (dest < 4'd5), 1);
                chk("b_dest_self", (dest != 4'd2), 1);
                chk("b_tail_data", {if_b.data_o[12], if_b.data_o[7:0]}, {1'b1, 8'd2});
                if (!b_phase) seq_q.push_back(dest);
                else if (seq_q.size() > 0) chk("b_repeat", dest, seq_q.pop_front());
                b_cnt++;
            end
        end
    end

    task automatic reset_a();
        @(posedge clk); #1;
        rst_a = 1'b1;
        en_a  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        starts.delete();
        mon_k     = 0;
        head_seen = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("a_done", done_a, 1);
    endtask

    task automatic wait_monk(input int target);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (mon_k != target && n < 50);
        chk("a_reach_flit", mon_k, target);
    endtask

    task automatic check_pair(input int gap);
        chk("a_starts", starts.size(), 2);
        if (starts.size() >= 2) chk("a_gap", starts[1] - starts[0], gap);
        chk("a_sent", sent_a, 2);
        chk("a_out_w_end", if_a.out_w, 0);
        chk("a_q_drained", exp_q.size(), 0);
    endtask

    task automatic run_stall(input int stall, input int gap);
        reset_a();
        push_packets(2);
        rst_a = 1'b0;
        en_a  = 1'b1;
        wait_monk(2);
        if_a.in_r = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            chk("a_stall_w", if_a.out_w, 1);
            chk("a_stall_d", if_a.data_o, exp_q[0]);
        end
        @(posedge clk); #1;
        if_a.in_r = 1'b1;
        wait_done_a(80);
        check_pair(gap);
    endtask

    initial begin
        int m_fl, m_pk, m_err, n;
        logic [FS-1:0] f;
        logic          t;
        logic [3:0]    ad;

        if_a.in_r = 1'b1; if_a.in_w = 1'b0; if_a.data_i = '0;
        if_b.in_r = 1'b1; if_b.in_w = 1'b0; if_b.data_i = '0;
        if_c.in_r = 1'b1; if_c.in_w = 1'b0; if_c.data_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_w", if_a.out_w, 0);
        chk("rst_data_o", if_a.data_o, 0);
        chk("rst_done", done_a, 0);
        chk("rst_out_r", if_a.out_r, 0);
        chk("rst_sent", sent_a, 0);
        chk("rst_rpk", rpk_a, 0);
        chk("rst_rfl", rfl_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_c_rfl", rfl_c, 0);

        // Two neighbour packets, no backpressure, 10 cycles apart, then done
        push_packets(2);
        @(posedge clk); #1;
        rst_a = 1'b0;
        en_a  = 1'b1;
        @(posedge clk); #1;
        chk("a_out_r_up", if_a.out_r, 1);
        wait_done_a(60);
        check_pair(10);
        repeat (5) @(negedge clk);
        chk("a_done_sticky", done_a, 1);
        chk("a_idle_out_w", if_a.out_w, 0);

        // Backpressure: short stall keeps period, long stall stretches the spacing
        run_stall(5, 10);
        run_stall(8, 12);

        // Receive statistics with generation disabled
        reset_a();
        rst_a = 1'b0;
        @(posedge clk); #1;
        m_fl = 0; m_pk = 0; m_err = 0;
        for (int i = 0; i < 4; i++) begin
            t  = (i >= 2);
            ad = (i == 3) ? 4'd3 : 4'd2;
            f  = {t, ad, 8'(i + 16)};
            if_a.data_i = f;
            if_a.in_w   = 1'b1;
            m_fl++;
            if (t) m_pk++;
            if (ad != 4'd2) m_err++;
            @(posedge clk); #1;
            $display("rx a n=%0d flit=%h", i, f);
        end
        if_a.in_w = 1'b0;
        @(negedge clk);
        chk("a_recv_flits", rfl_a, m_fl);
        chk("a_recv_packs", rpk_a, m_pk);
        chk("a_err_cnt", err_a, m_err);
        chk("a_rx_no_send", sent_a, 0);

        // Reset asserted while flit 2 is on the link
        push_packets(2);
        @(posedge clk); #1;
        en_a = 1'b1;
        wait_monk(2);
        chk("a_pre_rst_w", if_a.out_w, 1);
        rst_a = 1'b1;
        #1;
        chk("a_mid_rst_w", if_a.out_w, 0);
        chk("a_mid_rst_d", if_a.data_o, 0);
        chk("a_mid_rst_rfl", rfl_a, 0);
        chk("a_mid_rst_rpk", rpk_a, 0);
        chk("a_mid_rst_err", err_a, 0);
        chk("a_mid_rst_sent", sent_a, 0);
        exp_q.delete();
        starts.delete();
        mon_k     = 0;
        head_seen = 1'b0;
        push_packets(2);
        @(posedge clk); #1;
        rst_a = 1'b0;
        wait_done_a(60);
        check_pair(10);

        // Random destinations: 200 packets, then the same sequence after reset
        @(posedge clk); #1;
        rst_b = 1'b0;
        en_b  = 1'b1;
        n = 0;
        while (b_cnt < 200 && n < 600) begin
            @(posedge clk); #2;
            n++;
        end
        chk("b_run0_count", (b_cnt >= 200), 1);
        rst_b = 1'b1;
        en_b  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_phase = 1'b1;
        b_cnt   = 0;
        rst_b   = 1'b0;
        en_b    = 1'b1;
        n = 0;
        while (b_cnt < 200 && n < 600) begin
            @(posedge clk); #2;
            n++;
        end
        chk("b_run1_count", (b_cnt >= 200), 1);
        rst_b = 1'b1;
        en_b  = 1'b0;

        // Saturation of 4-bit receive counters over 20 flits
        @(posedge clk); #1;
        rst_c = 1'b0;
        @(posedge clk); #1;
        m_fl = 0; m_pk = 0; m_err = 0;
        for (int i = 0; i < 20; i++) begin
            t  = (i % 2 == 1);
            ad = (i % 4 == 3) ? 4'd1 : 4'd0;
            f  = {t, ad, 8'(i)};
            if_c.data_i = f;
            if_c.in_w   = 1'b1;
            if (m_fl < 15) m_fl++;
            if (t && m_pk < 15) m_pk++;
            if (ad != 4'd0 && m_err < 15) m_err++;
            @(posedge clk); #1;
            $display("rx c n=%0d flit=%h recv_flits=%0d", i, f, rfl_c);
            chk("c_recv_flits", rfl_c, m_fl);
            chk("c_recv_packs", rpk_c, m_pk);
            chk("c_err_cnt", err_c, m_err);
        end
        if_c.in_w = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
